// File: rtl/qeciphy_tx_framer.sv
// TX framer: inserts FAW / CRC-16 words into the user stream on boundary strobes, idle-fills otherwise.
// Optional macro QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN adds crc_err_inj_i for CRC error injection.
module qeciphy_tx_framer #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FAW_WORD  = 64'hF628_F628_F628_F628,
  parameter logic [DATA_W-1:0] IDLE_WORD = 64'h0707_0707_0707_0707,
  parameter logic [7:0]        CRC_TAG   = 8'hC3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              faw_boundary_i,
  input  logic              crc_boundary_i,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic [1:0]        tx_type_o,
  output logic [15:0]       frame_count_o,
  output logic              locked_o
`ifdef QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN
  ,
  input  logic              crc_err_inj_i
`endif
);

  typedef enum logic {ST_SYNC, ST_RUN} state_t;
  typedef enum logic [1:0] {
    TY_DATA = 2'b00,
    TY_IDLE = 2'b01,
    TY_FAW  = 2'b10,
    TY_CRC  = 2'b11
  } type_t;

  state_t            r_state;
  type_t             r_type;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_crc;
  logic [15:0]       r_frame_cnt;
  logic              r_locked;

  logic              w_run;
  logic              w_faw_sel;
  logic              w_crc_sel;
  logic              w_data_sel;
  logic [15:0]       w_crc16;
  logic [15:0]       w_crc_next;
  logic [DATA_W-1:0] w_word;
  type_t             w_type;

  // CRC-16/0x1021, whole word per cycle, MSB first
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [DATA_W-1:0] d_in);
    logic [15:0]       c;
    logic [DATA_W-1:0] d;
    logic              fb;
    c = crc_in;
    d = d_in;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb = c[15] ^ d[DATA_W-1];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
      d  = d << 1;
    end
    return c;
  endfunction

  assign w_run      = (r_state == ST_RUN);
  assign s_tready_o = w_run && !faw_boundary_i && !crc_boundary_i;
  assign w_faw_sel  = faw_boundary_i;
  assign w_crc_sel  = !faw_boundary_i && crc_boundary_i && w_run;
  assign w_data_sel = s_tready_o && s_tvalid_i;

`ifdef QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN
  logic r_inj_armed;

  assign w_crc16 = r_crc ^ {15'd0, r_inj_armed};

  // A pulse coinciding with a CRC word arms for the following one unless already armed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_inj_armed <= 1'b0;
    end else if (w_crc_sel) begin
      r_inj_armed <= crc_err_inj_i && !r_inj_armed;
    end else begin
      r_inj_armed <= r_inj_armed || crc_err_inj_i;
    end
  end
`else
  assign w_crc16 = r_crc;
`endif

  always_comb begin
    w_word     = IDLE_WORD;
    w_type     = TY_IDLE;
    w_crc_next = r_crc;
    if (w_faw_sel) begin
      w_word     = FAW_WORD;
      w_type     = TY_FAW;
      w_crc_next = 16'hFFFF;
    end else if (w_crc_sel) begin
      w_word     = {CRC_TAG, {(DATA_W-24){1'b0}}, w_crc16};
      w_type     = TY_CRC;
      w_crc_next = 16'hFFFF;
    end else if (w_data_sel) begin
      w_word     = s_tdata_i;
      w_type     = TY_DATA;
      w_crc_next = crc16_word(r_crc, s_tdata_i);
    end else if (w_run) begin
      w_crc_next = crc16_word(r_crc, IDLE_WORD);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_SYNC;
      r_type      <= TY_IDLE;
      r_data      <= IDLE_WORD;
      r_crc       <= 16'hFFFF;
      r_frame_cnt <= '0;
      r_locked    <= 1'b0;
    end else begin
      r_type <= w_type;
      r_data <= w_word;
      r_crc  <= w_crc_next;
      if (w_faw_sel) begin
        r_state     <= ST_RUN;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_locked    <= 1'b1;
      end
    end
  end

  assign tx_data_o     = r_data;
  assign tx_type_o     = r_type;
  assign frame_count_o = r_frame_cnt;
  assign locked_o      = r_locked;

endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Directed bench for qeciphy_tx_framer; expected words come from a behavioural reference model.
module tb_qeciphy_tx_framer;

  localparam logic [63:0] FAW_W  = 64'hF628_F628_F628_F628;
  localparam logic [63:0] IDLE_W = 64'h0707_0707_0707_0707;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        faw_b, crc_b, tvalid, inj;
  logic [63:0] tdata;
  logic        tready;
  logic [63:0] tx_data;
  logic [1:0]  tx_type;
  logic [15:0] fcount;
  logic        locked;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic        m_run    = 1'b0;
  logic [15:0] m_crc    = 16'hFFFF;
  logic [15:0] m_fc     = 16'd0;
  logic        m_locked = 1'b0;
  logic        m_arm    = 1'b0;

  always #5 clk = ~clk;

  qeciphy_tx_framer dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .faw_boundary_i (faw_b),
    .crc_boundary_i (crc_b),
    .s_tdata_i      (tdata),
    .s_tvalid_i     (tvalid),
    .s_tready_o     (tready),
    .tx_data_o      (tx_data),
    .tx_type_o      (tx_type),
    .frame_count_o  (fcount),
    .locked_o       (locked)
`ifdef QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN
    ,
    .crc_err_inj_i  (inj)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc(input logic [15:0] c_in, input logic [63:0] w);
    logic [15:0] c;
    logic [63:0] d;
    c = c_in;
    d = w;
    for (int i = 0; i < 64; i++) begin
      if (c[15] ^ d[63]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else               c = {c[14:0], 1'b0};
      d = d << 1;
    end
    return c;
  endfunction

  // One clock: drive at posedge+1, check tready before the edge, check outputs at posedge+1.
  task automatic cyc(input logic faw, input logic crc, input logic v, input logic [63:0] d,
                     input string tag);
    logic        e_rdy;
    logic [1:0]  e_type;
    logic [63:0] e_data;
    logic        crc_sel;
    faw_b  = faw;
    crc_b  = crc;
    tvalid = v;
    tdata  = d;
    e_rdy  = m_run && !faw && !crc;
    crc_sel = 1'b0;
    if (faw) begin
      e_type = 2'b10; e_data = FAW_W; m_crc = 16'hFFFF;
      m_run = 1'b1; m_fc = m_fc + 16'd1; m_locked = 1'b1;
    end else if (crc && m_run) begin
      crc_sel = 1'b1;
      e_type = 2'b11; e_data = {8'hC3, 40'd0, m_crc ^ {15'd0, m_arm}}; m_crc = 16'hFFFF;
    end else if (m_run && v) begin
      e_type = 2'b00; e_data = d; m_crc = ref_crc(m_crc, d);
    end else begin
      e_type = 2'b01; e_data = IDLE_W;
      if (m_run) m_crc = ref_crc(m_crc, IDLE_W);
    end
`ifdef QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN
    m_arm = crc_sel ? (inj && !m_arm) : (m_arm || inj);
`endif
    #2;
    check({tag, ".tready"}, {63'd0, tready}, {63'd0, e_rdy});
    @(posedge clk);
    #1;
    check({tag, ".type"},   {62'd0, tx_type}, {62'd0, e_type});
    check({tag, ".data"},   tx_data, e_data);
    check({tag, ".fcount"}, {48'd0, fcount}, {48'd0, m_fc});
    check({tag, ".locked"}, {63'd0, locked}, {63'd0, m_locked});
    inj = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; faw_b = 1'b0; crc_b = 1'b0; tvalid = 1'b0; tdata = '0; inj = 1'b0;
    #12;
    check("rst.type",   {62'd0, tx_type}, 64'd1);
    check("rst.data",   tx_data, IDLE_W);
    check("rst.tready", {63'd0, tready}, 64'd0);
    check("rst.fcount", {48'd0, fcount}, 64'd0);
    check("rst.locked", {63'd0, locked}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // SYNC ignores CRC strobes and valid data
    cyc(1'b0, 1'b1, 1'b1, 64'hAA, "sync_crc");
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 64'hBB, "sync_idle");
    cyc(1'b1, 1'b0, 1'b0, 64'd0, "faw1");
    check("faw1.locked_hi", {63'd0, locked}, 64'd1);
    check("faw1.fcount_1",  {48'd0, fcount}, 64'd1);

    for (int k = 1; k <= 6; k++) cyc(1'b0, 1'b0, 1'b1, 64'(k), "data");
    cyc(1'b0, 1'b1, 1'b1, 64'd7, "crc1");
    check("crc1.tag", {56'd0, tx_data[63:56]}, 64'hC3);
    cyc(1'b0, 1'b0, 1'b1, 64'd7, "held7");

    // FAW beats CRC; next CRC covers only words after the FAW
    cyc(1'b1, 1'b1, 1'b1, 64'd8, "faw_crc");
    cyc(1'b0, 1'b0, 1'b1, 64'd8, "held8");
    cyc(1'b0, 1'b0, 1'b1, 64'd9, "d9");
    cyc(1'b0, 1'b1, 1'b0, 64'd0, "crc2");

    // whole idle frame
    cyc(1'b1, 1'b0, 1'b0, 64'd0, "faw3");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 64'd0, "idle");
    cyc(1'b0, 1'b1, 1'b0, 64'd0, "crc3");

`ifdef QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN
    inj = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 64'h1234, "inj_arm");
    inj = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 64'h5678, "inj_absorb");
    cyc(1'b0, 1'b1, 1'b0, 64'd0, "crc_inj");
    cyc(1'b0, 1'b0, 1'b1, 64'h9ABC, "post_inj");
    cyc(1'b0, 1'b1, 1'b0, 64'd0, "crc_clean");
`endif

    // asynchronous reset mid-frame
    cyc(1'b1, 1'b0, 1'b0, 64'd0, "faw4");
    cyc(1'b0, 1'b0, 1'b1, 64'h55, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.type",   {62'd0, tx_type}, 64'd1);
    check("arst.data",   tx_data, IDLE_W);
    check("arst.tready", {63'd0, tready}, 64'd0);
    check("arst.fcount", {48'd0, fcount}, 64'd0);
    check("arst.locked", {63'd0, locked}, 64'd0);
    m_run = 1'b0; m_crc = 16'hFFFF; m_fc = 16'd0; m_locked = 1'b0; m_arm = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 64'h66, "post_rst");
    cyc(1'b0, 1'b1, 1'b1, 64'h66, "post_rst_crc");
    cyc(1'b1, 1'b0, 1'b1, 64'h66, "faw5");
    cyc(1'b0, 1'b0, 1'b1, 64'h66, "d66");
    cyc(1'b0, 1'b1, 1'b0, 64'd0, "crc5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qeciphy_tx_framer.md
QECIPHY_TX_FRAMER -- requirements
Module: qeciphy_tx_framer

Interface
REQ-001 Parameter DATA_W, default 64, width in bits of every data word and every output word.
REQ-002 Parameter FAW_WORD, default 64'hF628_F628_F628_F628, Frame Alignment Word pattern.
REQ-003 Parameter IDLE_WORD, default 64'h0707_0707_0707_0707, filler word sent when no user data is available.
REQ-004 Parameter CRC_TAG, default 8'hC3, tag byte placed in the top bits of every CRC word.
REQ-005 Port clk_i, input, 1: the only clock; every register is clocked on its rising edge.
REQ-006 Port rst_n_i, input, 1: reset, asynchronous assert, active-low.
REQ-007 Port faw_boundary_i, input, 1: FAW slot strobe from the TX boundary generator.
REQ-008 Port crc_boundary_i, input, 1: CRC slot strobe from the TX boundary generator.
REQ-009 Port s_tdata_i, input, DATA_W: user data word.
REQ-010 Port s_tvalid_i, input, 1: s_tdata_i is valid.
REQ-011 Port s_tready_o, output, 1: the framer accepts s_tdata_i in this cycle.
REQ-012 Port tx_data_o, output, DATA_W: framed word to the PCS/transceiver.
REQ-013 Port tx_type_o, output, 2: type of tx_data_o; 00 = data, 01 = idle, 10 = FAW, 11 = CRC.
REQ-014 Port frame_count_o, output, 16: number of FAW words sent; wraps from 16'hFFFF to 0.
REQ-015 Port locked_o, output, 1: high once the first FAW word has been sent.

Function
REQ-016 Two states.
- SYNC (reset state): wait for the first faw_boundary_i.
- RUN: framing active.
- SYNC -> RUN on the first faw_boundary_i; no other transition except reset.
REQ-017 Each input cycle's decision is registered; tx_data_o and tx_type_o appear exactly 1 cycle after the strobes and the input handshake that selected them.
REQ-018 Word selection per cycle, priority order:
- faw_boundary_i -> FAW_WORD, type 10.
- else crc_boundary_i in RUN -> CRC word, type 11.
- else in RUN with s_tvalid_i -> s_tdata_i, type 00.
- else -> IDLE_WORD, type 01.
REQ-019 s_tready_o is combinational: 1 only in RUN with faw_boundary_i = 0 and crc_boundary_i = 0; a transfer occurs when s_tvalid_i and s_tready_o are both 1.
REQ-020 In SYNC, s_tready_o = 0 and crc_boundary_i is ignored.
REQ-021 CRC algorithm: CRC-16, polynomial 0x1021, init 0xFFFF, no reflection, no final XOR.
- Each word is processed MSB first, full DATA_W bits in one cycle.
REQ-022 The CRC accumulates over every data and idle word emitted in RUN.
REQ-023 The CRC word is {CRC_TAG, (DATA_W-24) zero bits, crc16}, where crc16 is the accumulator value before the CRC cycle.
REQ-024 The accumulator reloads to 0xFFFF in the cycle a CRC word or a FAW word is selected.
REQ-025 When faw_boundary_i and crc_boundary_i are high together, FAW wins, no CRC word is emitted, and the accumulator reloads.
REQ-026 frame_count_o increments in the same cycle tx_type_o = 10 is driven; locked_o rises with the first FAW output and stays high.
REQ-027 A word offered while s_tready_o = 0 is never lost or duplicated; the upstream holds it, stable, until accepted.

Reset
REQ-028 While rst_n_i = 0:
- state = SYNC, tx_data_o = IDLE_WORD, tx_type_o = 01, s_tready_o = 0.
- frame_count_o = 0, locked_o = 0, accumulator = 0xFFFF.
REQ-029 Reset asserted mid-frame takes effect immediately (asynchronously); after release the block re-enters SYNC and discards the partial CRC.

Configuration
REQ-030 Macro QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN selects CRC error injection.
- Defined: adds input crc_err_inj_i (1 bit). A pulse arms a flag; the next CRC word has crc16 bit 0 inverted, then the flag clears. Pulses while armed are absorbed.
- Undefined: port absent and CRC words are always correct.

Verification
REQ-031 Reset, then FAW strobe at cycle 10 -> tx_type_o = 10 at cycle 11, tx_data_o = 64'hF628_F628_F628_F628, locked_o = 1, frame_count_o = 1.
REQ-032 RUN, s_tvalid_i held high with incrementing data 1..6, CRC strobe on the 7th cycle -> six type-00 words 1..6, then a type-11 word whose crc16 matches the reference model and whose top byte = 8'hC3.
REQ-033 FAW and CRC strobes high in the same cycle -> a single type-10 word, no CRC word, and the next CRC covers only words after the FAW.
REQ-034 s_tvalid_i = 0 for a whole frame -> only type-01 words 64'h0707_0707_0707_0707 between FAW and CRC slots, and the CRC equals the model over the idle words.
REQ-035 rst_n_i pulsed low mid-frame -> outputs at reset values without waiting for a clock edge, s_tready_o = 0 until the next FAW strobe.
REQ-036 With QECIPHY_TX_FRAMER_CRC_ERR_INJ_EN defined, a pulse on crc_err_inj_i -> only the next CRC word differs from the model, in bit 0.
